// File: rtl/moesi_snoop_responder.sv
// Snoop-side MOESI agent for one core: looks up broadcast requests from other
// cores in a small direct-mapped tag/state array, answers the snoop in the bus
// completion cycle, applies the snoop transition and hands dirty lines to the
// writeback/data-supply consumer.
module moesi_snoop_responder #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int CORE_ID    = 0,
    parameter int LINE_BYTES = 64,
    parameter int NUM_LINES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_valid,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [1:0]            bus_type,
    input  logic [1:0]            granted_core_id,
    output logic                  snoop_resp,
    output logic                  snoop_dirty,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_ready,
    input  logic                  loc_wr_valid,
    input  logic [ADDR_WIDTH-1:0] loc_wr_addr,
    input  logic [2:0]            loc_wr_state,
    output logic                  loc_wr_ready,
    input  logic [ADDR_WIDTH-1:0] loc_rd_addr,
    output logic [2:0]            loc_rd_state,
    output logic                  busy,
    output logic                  err_overrun,
    output logic                  err_upgr
);

    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFF - IDX;

    localparam logic [1:0] CORE_ID_L = 2'(CORE_ID);

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_S = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_O = 3'd3;
    localparam logic [2:0] ST_M = 3'd4;

    localparam logic [1:0] BUS_RD   = 2'b00;
    localparam logic [1:0] BUS_RDX  = 2'b01;
    localparam logic [1:0] BUS_UPGR = 2'b10;
    localparam logic [1:0] BUS_NOP  = 2'b11;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_UPDATE = 2'd1,
        FSM_SUPPLY = 2'd2
    } fsm_t;

    // MOESI transition applied to a hit line by a remote request.
    function automatic logic [2:0] f_snoop_next(input logic [2:0] old_st,
                                                input logic [1:0] typ);
        logic [2:0] nxt;
        nxt = old_st;
        case (typ)
            BUS_RD: begin
                if (old_st == ST_M)      nxt = ST_O;
                else if (old_st == ST_E) nxt = ST_S;
                else                     nxt = old_st;
            end
            BUS_RDX:  nxt = ST_I;
            BUS_UPGR: nxt = ST_I;
            default:  nxt = old_st;
        endcase
        return nxt;
    endfunction

    // Encodings above M are not legal MOESI states; store them as Invalid.
    function automatic logic [2:0] f_clamp_state(input logic [2:0] st);
        return (st > ST_M) ? ST_I : st;
    endfunction

    // Tag/state array
    logic [TAG_W-1:0] r_tag   [NUM_LINES];
    logic [2:0]       r_state [NUM_LINES];

    // FSM and registered outputs
    fsm_t r_fsm;
    fsm_t w_fsm_next;
    logic r_snoop_resp;
    logic r_snoop_dirty;
    logic r_hit_l;
    logic r_err_overrun;
    logic r_err_upgr;

    // Snoop context latched at capture, consumed in UPDATE / SUPPLY
    logic [IDX-1:0]   r_idx;
    logic [TAG_W-1:0] r_ltag;
    logic [2:0]       r_old;
    logic [1:0]       r_type;

    // Combinational lookups
    logic [IDX-1:0]   w_bus_idx;
    logic [TAG_W-1:0] w_bus_tag;
    logic [2:0]       w_bus_state;
    logic             w_bus_hit;
    logic [IDX-1:0]   w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX-1:0]   w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;

    logic             w_remote;
    logic             w_capture;
    logic             w_overrun;
    logic             w_upd_we;
    logic [2:0]       w_upd_state;
    logic             w_upgr_err;
    logic             w_loc_we;
    logic             w_unused;

    assign w_bus_idx   = bus_addr[OFF+IDX-1:OFF];
    assign w_bus_tag   = bus_addr[ADDR_WIDTH-1:OFF+IDX];
    assign w_bus_state = r_state[w_bus_idx];
    assign w_bus_hit   = (r_tag[w_bus_idx] == w_bus_tag) && (w_bus_state != ST_I);

    assign w_rd_idx = loc_rd_addr[OFF+IDX-1:OFF];
    assign w_rd_tag = loc_rd_addr[ADDR_WIDTH-1:OFF+IDX];
    assign w_wr_idx = loc_wr_addr[OFF+IDX-1:OFF];
    assign w_wr_tag = loc_wr_addr[ADDR_WIDTH-1:OFF+IDX];

    assign loc_rd_state = ((r_tag[w_rd_idx] == w_rd_tag) && (r_state[w_rd_idx] != ST_I))
                          ? r_state[w_rd_idx] : ST_I;

    // Own-core broadcasts are invisible to this agent.
    assign w_remote  = bus_valid && (granted_core_id != CORE_ID_L)
                       && (int'(granted_core_id) < NUM_CORES);
    assign w_capture = w_remote && (r_fsm == FSM_IDLE);
    assign w_overrun = w_remote && (r_fsm != FSM_IDLE);

    // No-op broadcasts report presence but never modify the line.
    assign w_upd_we    = (r_fsm == FSM_UPDATE) && r_hit_l && (r_type != BUS_NOP);
    assign w_upd_state = f_snoop_next(r_old, r_type);
    assign w_upgr_err  = (r_fsm == FSM_UPDATE) && r_hit_l && (r_type == BUS_UPGR)
                         && ((r_old == ST_E) || (r_old == ST_M));
    assign w_loc_we    = loc_wr_valid && loc_wr_ready;

    assign snoop_resp  = r_snoop_resp;
    assign snoop_dirty = r_snoop_dirty;
    assign err_overrun = r_err_overrun;
    assign err_upgr    = r_err_upgr;

    assign w_unused = ^{bus_addr[OFF-1:0], loc_wr_addr[OFF-1:0], loc_rd_addr[OFF-1:0]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_fsm <= FSM_IDLE;
        else     r_fsm <= w_fsm_next;
    end

    // Next-state logic and FSM-derived outputs
    always_comb begin
        w_fsm_next   = r_fsm;
        busy         = 1'b0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        loc_wr_ready = 1'b1;
        case (r_fsm)
            FSM_IDLE: begin
                // A capture in this cycle may target the index being written.
                loc_wr_ready = !w_capture;
                if (w_capture) w_fsm_next = FSM_UPDATE;
            end
            FSM_UPDATE: begin
                busy         = 1'b1;
                loc_wr_ready = 1'b0;
                w_fsm_next   = r_snoop_dirty ? FSM_SUPPLY : FSM_IDLE;
            end
            FSM_SUPPLY: begin
                busy     = 1'b1;
                wb_valid = 1'b1;
                wb_addr  = {r_ltag, r_idx, {OFF{1'b0}}};
                if (wb_ready) w_fsm_next = FSM_IDLE;
            end
            default: w_fsm_next = FSM_IDLE;
        endcase
    end

    // Snoop response pulse, hit flag and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snoop_resp  <= 1'b0;
            r_snoop_dirty <= 1'b0;
            r_hit_l       <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_upgr    <= 1'b0;
        end else begin
            r_snoop_resp  <= w_capture && w_bus_hit;
            r_snoop_dirty <= w_capture && w_bus_hit
                             && ((w_bus_state == ST_M) || (w_bus_state == ST_O))
                             && ((bus_type == BUS_RD) || (bus_type == BUS_RDX));
            if (w_capture)  r_hit_l       <= w_bus_hit;
            if (w_overrun)  r_err_overrun <= 1'b1;
            if (w_upgr_err) r_err_upgr    <= 1'b1;
        end
    end

    // Snoop context capture
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_idx  <= w_bus_idx;
            r_ltag <= w_bus_tag;
            r_old  <= w_bus_state;
            r_type <= bus_type;
        end
    end

    // State array: snoop transitions in UPDATE, local installs otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) r_state[i] <= ST_I;
        end else begin
            if (w_upd_we) r_state[r_idx]    <= w_upd_state;
            if (w_loc_we) r_state[w_wr_idx] <= f_clamp_state(loc_wr_state);
        end
    end

    // Tag array: only local installs change a tag
    always_ff @(posedge clk) begin
        if (w_loc_we) r_tag[w_wr_idx] <= w_wr_tag;
    end

endmodule

// File: tb/tb_moesi_snoop_responder.sv
// Directed bench for moesi_snoop_responder: stimulus pushes cycle-stamped
// expectations and supply addresses into queues, a negedge monitor compares.
module tb_moesi_snoop_responder;

    localparam int AW = 64;

    localparam int S_RESP  = 0;
    localparam int S_DIRTY = 1;
    localparam int S_WBV   = 2;
    localparam int S_WBA   = 3;
    localparam int S_RD    = 4;
    localparam int S_WRR   = 5;
    localparam int S_BUSY  = 6;
    localparam int S_OVR   = 7;
    localparam int S_UPG   = 8;

    localparam logic [2:0] I = 3'd0, S = 3'd1, E = 3'd2, O = 3'd3, M = 3'd4;
    localparam logic [1:0] RD = 2'b00, RDX = 2'b01, UPGR = 2'b10, NOP = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_valid;
    logic [AW-1:0] bus_addr;
    logic [1:0]    bus_type;
    logic [1:0]    granted_core_id;
    logic          snoop_resp;
    logic          snoop_dirty;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic          wb_ready;
    logic          loc_wr_valid;
    logic [AW-1:0] loc_wr_addr;
    logic [2:0]    loc_wr_state;
    logic          loc_wr_ready;
    logic [AW-1:0] loc_rd_addr;
    logic [2:0]    loc_rd_state;
    logic          busy;
    logic          err_overrun;
    logic          err_upgr;

    moesi_snoop_responder #(
        .NUM_CORES(4), .ADDR_WIDTH(AW), .CORE_ID(0), .LINE_BYTES(64), .NUM_LINES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_type(bus_type),
        .granted_core_id(granted_core_id),
        .snoop_resp(snoop_resp), .snoop_dirty(snoop_dirty),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
        .loc_wr_valid(loc_wr_valid), .loc_wr_addr(loc_wr_addr),
        .loc_wr_state(loc_wr_state), .loc_wr_ready(loc_wr_ready),
        .loc_rd_addr(loc_rd_addr), .loc_rd_state(loc_rd_state),
        .busy(busy), .err_overrun(err_overrun), .err_upgr(err_upgr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t        exp_q[$];
    logic [63:0] wb_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual_of(input int s);
        case (s)
            S_RESP:  return {63'd0, snoop_resp};
            S_DIRTY: return {63'd0, snoop_dirty};
            S_WBV:   return {63'd0, wb_valid};
            S_WBA:   return wb_addr;
            S_RD:    return {61'd0, loc_rd_state};
            S_WRR:   return {63'd0, loc_wr_ready};
            S_BUSY:  return {63'd0, busy};
            S_OVR:   return {63'd0, err_overrun};
            S_UPG:   return {63'd0, err_upgr};
            default: return 64'hDEAD;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle and every supply handshake
    always @(negedge clk) begin
        logic [63:0] act;
        logic [63:0] want;
        if (!done) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    n_chk++;
                    act = actual_of(exp_q[i].sig);
                    if (act !== exp_q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d: got 0x%0h, required 0x%0h",
                                 exp_q[i].name, cyc, act, exp_q[i].exp);
                    end
                    exp_q.delete(i);
                end
            end
            if (wb_valid && wb_ready) begin
                n_chk++;
                if (wb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_handshake cyc=%0d: got unexpected supply 0x%0h, required none",
                             cyc, wb_addr);
                end else begin
                    want = wb_q.pop_front();
                    if (wb_addr !== want) begin
                        n_fail++;
                        $display("FAIL wb_handshake_addr cyc=%0d: got 0x%0h, required 0x%0h",
                                 cyc, wb_addr, want);
                    end
                end
            end
        end else begin
            n_chk++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_checks: got %0d unevaluated, required 0", exp_q.size());
            end
            n_chk++;
            if (wb_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_supply: got %0d supplies missing, required 0", wb_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [63:0] v, input string n);
        chk_t e;
        e.cyc = c; e.sig = s; e.exp = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic rd_chk(input logic [63:0] a, input logic [2:0] v, input string n);
        loc_rd_addr = a;
        expect_at(cyc, S_RD, {61'd0, v}, n);
    endtask

    task automatic loc_write(input logic [63:0] a, input logic [2:0] st);
        loc_wr_valid = 1'b1;
        loc_wr_addr  = a;
        loc_wr_state = st;
        tick();
        loc_wr_valid = 1'b0;
    endtask

    // Drives one broadcast in the current cycle; returns in the following cycle.
    task automatic snoop(input logic [63:0] a, input logic [1:0] t, input logic [1:0] gid);
        bus_valid       = 1'b1;
        bus_addr        = a;
        bus_type        = t;
        granted_core_id = gid;
        tick();
        bus_valid = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1; bus_valid = 1'b0; bus_addr = '0; bus_type = NOP; granted_core_id = 2'd0;
        wb_ready = 1'b0; loc_wr_valid = 1'b0; loc_wr_addr = '0; loc_wr_state = I; loc_rd_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        t = cyc;
        rd_chk(64'h0, I, "rst_rd_0x0");
        expect_at(t, S_RESP, 0, "rst_resp");
        expect_at(t, S_DIRTY, 0, "rst_dirty");
        expect_at(t, S_WBV, 0, "rst_wbv");
        expect_at(t, S_WBA, 0, "rst_wba");
        expect_at(t, S_BUSY, 0, "rst_busy");
        expect_at(t, S_OVR, 0, "rst_ovr");
        expect_at(t, S_UPG, 0, "rst_upg");
        expect_at(t, S_WRR, 1, "rst_wrr");
        tick(); rd_chk(64'h40, I, "rst_rd_0x40");
        tick(); rd_chk(64'h3C0, I, "rst_rd_0x3c0");
        tick();

        // Dirty BusRd: M -> O with supply
        loc_write(64'h1000, M);
        t = cyc;
        expect_at(t, S_WRR, 0, "rd_m_wrr_T");
        snoop(64'h1000, RD, 2'd1);
        expect_at(t+1, S_RESP, 1, "rd_m_resp");
        expect_at(t+1, S_DIRTY, 1, "rd_m_dirty");
        expect_at(t+1, S_BUSY, 1, "rd_m_busy_T1");
        expect_at(t+1, S_WRR, 0, "rd_m_wrr_T1");
        tick();
        rd_chk(64'h1000, O, "rd_m_state_O");
        expect_at(t+2, S_WBV, 1, "rd_m_wbv_T2");
        expect_at(t+2, S_WBA, 64'h1000, "rd_m_wba_T2");
        expect_at(t+2, S_RESP, 0, "rd_m_resp_T2");
        tick();
        expect_at(t+3, S_WBV, 1, "rd_m_wbv_hold");
        expect_at(t+3, S_WBA, 64'h1000, "rd_m_wba_hold");
        tick();
        wb_ready = 1'b1;
        wb_q.push_back(64'h1000);
        expect_at(t+4, S_BUSY, 1, "rd_m_busy_hs");
        tick();
        wb_ready = 1'b0;
        expect_at(t+5, S_WBV, 0, "rd_m_wbv_after");
        expect_at(t+5, S_BUSY, 0, "rd_m_busy_after");
        tick();

        // Clean BusRdX: S -> I, no supply
        loc_write(64'h2040, S);
        t = cyc;
        snoop(64'h2040, RDX, 2'd2);
        expect_at(t+1, S_RESP, 1, "rdx_s_resp");
        expect_at(t+1, S_DIRTY, 0, "rdx_s_dirty");
        tick();
        rd_chk(64'h2040, I, "rdx_s_state_I");
        expect_at(t+2, S_WBV, 0, "rdx_s_wbv");
        expect_at(t+2, S_BUSY, 0, "rdx_s_busy_T2");
        tick();
        expect_at(t+3, S_WBV, 0, "rdx_s_wbv_T3");
        tick();

        // Tag mismatch, then own-core broadcast
        loc_write(64'h1000, S);
        t = cyc;
        snoop(64'h1400, RD, 2'd1);
        expect_at(t+1, S_RESP, 0, "miss_resp");
        expect_at(t+1, S_BUSY, 1, "miss_busy");
        tick();
        rd_chk(64'h1000, S, "miss_keep_S");
        tick();
        t = cyc;
        expect_at(t, S_WRR, 1, "own_wrr");
        snoop(64'h1000, RD, 2'd0);
        expect_at(t+1, S_RESP, 0, "own_resp");
        expect_at(t+1, S_BUSY, 0, "own_busy");
        tick();
        rd_chk(64'h1000, S, "own_keep_S");
        tick();

        // BusRd on E -> S, then a no-op broadcast on the S line
        loc_write(64'h3000, E);
        t = cyc;
        snoop(64'h3000, RD, 2'd2);
        expect_at(t+1, S_RESP, 1, "rd_e_resp");
        expect_at(t+1, S_DIRTY, 0, "rd_e_dirty");
        tick();
        rd_chk(64'h3000, S, "rd_e_state_S");
        tick();
        t = cyc;
        snoop(64'h3000, NOP, 2'd3);
        expect_at(t+1, S_RESP, 1, "nop_resp");
        expect_at(t+1, S_DIRTY, 0, "nop_dirty");
        tick();
        rd_chk(64'h3000, S, "nop_keep_S");
        tick();

        // BusUpgr on E: error flag, line invalidated
        loc_write(64'h80, E);
        t = cyc;
        snoop(64'h80, UPGR, 2'd1);
        expect_at(t+1, S_RESP, 1, "upgr_resp");
        expect_at(t+1, S_DIRTY, 0, "upgr_dirty");
        expect_at(t+1, S_UPG, 0, "upgr_flag_T1");
        tick();
        rd_chk(64'h80, I, "upgr_state_I");
        expect_at(t+2, S_UPG, 1, "upgr_flag_T2");
        tick(); tick(); tick();
        expect_at(t+5, S_UPG, 1, "upgr_flag_sticky");
        tick();

        // Local write held off during capture/UPDATE, then overrun during supply
        loc_write(64'h80, M);
        t = cyc;
        expect_at(t, S_WRR, 0, "lw_wrr_T");
        loc_wr_valid = 1'b1; loc_wr_addr = 64'hC0; loc_wr_state = E;
        snoop(64'h80, RD, 2'd1);
        expect_at(t+1, S_WRR, 0, "lw_wrr_T1");
        expect_at(t+1, S_RESP, 1, "lw_snoop_resp");
        expect_at(t+1, S_DIRTY, 1, "lw_snoop_dirty");
        rd_chk(64'hC0, I, "lw_not_yet_T1");
        tick();
        expect_at(t+2, S_WRR, 1, "lw_wrr_T2");
        expect_at(t+2, S_WBV, 1, "sup_wbv_T2");
        expect_at(t+2, S_WBA, 64'h80, "sup_wba_T2");
        rd_chk(64'h80, O, "sup_state_O");
        tick();
        loc_wr_valid = 1'b0;
        rd_chk(64'hC0, E, "lw_landed");
        expect_at(t+3, S_WRR, 1, "ovr_wrr_supply");
        bus_valid = 1'b1; bus_addr = 64'hC0; bus_type = RD; granted_core_id = 2'd3;
        tick();
        bus_valid = 1'b0;
        expect_at(t+4, S_OVR, 1, "ovr_flag");
        expect_at(t+4, S_RESP, 0, "ovr_resp");
        expect_at(t+4, S_BUSY, 1, "ovr_busy");
        expect_at(t+4, S_WBV, 1, "ovr_wbv_hold");
        tick();
        rd_chk(64'hC0, E, "ovr_state_kept");
        expect_at(t+5, S_WBA, 64'h80, "ovr_wba_hold");
        expect_at(t+5, S_OVR, 1, "ovr_flag_sticky");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_at(t+6, S_WBV, 0, "rst2_wbv");
        expect_at(t+6, S_OVR, 0, "rst2_ovr");
        expect_at(t+6, S_UPG, 0, "rst2_upg");
        expect_at(t+6, S_BUSY, 0, "rst2_busy");
        expect_at(t+6, S_WBA, 0, "rst2_wba");
        rd_chk(64'h80, I, "rst2_state_I");
        tick();
        expect_at(t+7, S_WRR, 1, "rst2_wrr");
        rd_chk(64'hC0, I, "rst2_c0_I");
        tick(); tick();
        done = 1'b1;
    end

endmodule

// File: doc/moesi_snoop_responder.md
# moesi_snoop_responder

- Per-core snoop-side agent that sits on the receive end of the coherency bus.
- Watches each broadcast request from another core and looks the address up in a small local tag/MOESI state array. Returns this core's snoop response bit in the bus's completion cycle, applies the MOESI snoop transition, and issues a data-supply/writeback handshake when the line was dirty.
- One instance per core; its `snoop_resp` drives bit `CORE_ID` of the bus's snoop response vector.

## Interface
- `NUM_CORES`, 4, number of cores on the bus; `granted_core_id` width is fixed at 2.
- `ADDR_WIDTH`, 64, byte address width.
- `CORE_ID`, 0, index of the owning core.
- `LINE_BYTES`, 64, line size, power of 2; `OFF = log2(LINE_BYTES)`.
- `NUM_LINES`, 16, direct-mapped entries, power of 2; `IDX = log2(NUM_LINES)`.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_valid`  in  1  broadcast valid, one cycle per request.
- `bus_addr`  in  ADDR_WIDTH  broadcast address.
- `bus_type`  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 no-op.
- `granted_core_id`  in  2  requester of the current broadcast.
- `snoop_resp`  out  1  line present (S/E/O/M) at snoop time.
- `snoop_dirty`  out  1  this core owns dirty data (M/O) and will supply it.
- `wb_valid`  out  1  data-supply request pending.
- `wb_addr`  out  ADDR_WIDTH  line-aligned address of the supplied line; low OFF bits are 0.
- `wb_ready`  in  1  consumer accepts the supply.
- `loc_wr_valid`  in  1  core installs or updates a line.
- `loc_wr_addr`  in  ADDR_WIDTH  line address for the local write.
- `loc_wr_state`  in  3  new state: I=0, S=1, E=2, O=3, M=4.
- `loc_wr_ready`  out  1  local write accepted this cycle.
- `loc_rd_addr`  in  ADDR_WIDTH  combinational state query address.
- `loc_rd_state`  out  3  state of `loc_rd_addr`; I on invalid entry or tag mismatch.
- `busy`  out  1  FSM not IDLE.
- `err_overrun`  out  1  sticky; a snoop arrived while busy.
- `err_upgr`  out  1  sticky; BusUpgr hit a line in E or M.

## Operation
- Array fields per entry: tag = `addr[ADDR_WIDTH-1:OFF+IDX]`, index = `addr[OFF+IDX-1:OFF]`, 3-bit state. A hit requires the tags to match and state ≠ I.
- Remote snoop: `bus_valid && granted_core_id != CORE_ID`. Own-core broadcasts are ignored entirely: no response, no state change.
- FSM states: IDLE, UPDATE, SUPPLY.
- IDLE, on remote snoop:
  - Read the array combinationally on `bus_addr`.
  - Register `snoop_resp` = hit.
  - Register `snoop_dirty` = hit && old state ∈ {M, O} && type ∈ {BusRd, BusRdX}.
  - Latch index, tag, old state and type; go to UPDATE.
  - Type 11: `snoop_resp` still reports the hit, but no transition follows.
- UPDATE writes the new state to the array:
  - BusRd: M→O, E→S; O, S and I unchanged.
  - BusRdX: any→I.
  - BusUpgr: S→I, O→I. E or M hit sets `err_upgr` and the line goes to I.
  - Miss: no write.
  - Next state: SUPPLY if `snoop_dirty`, else IDLE.
- SUPPLY:
  - `wb_valid`=1 with `wb_addr` = {latched tag, index, OFF zeros}.
  - Outputs stay stable until `wb_ready`; in the handshake cycle the FSM returns to IDLE.
- Remote snoop while in UPDATE or SUPPLY sets `err_overrun`. That snoop is dropped: no response, no state change.
- Local write:
  - `loc_wr_ready` = !(state==UPDATE) && !(remote snoop in IDLE this cycle).
  - When `loc_wr_valid && loc_wr_ready`, write tag and state at the edge.
  - `loc_wr_state` > 4 is written as I.
- Reset:
  - All entries go to I; FSM to IDLE.
  - All outputs are 0, including the sticky error flags.
  - Reset during SUPPLY drops the pending supply; `wb_valid` is 0 the cycle after `rst`.

## Timing
- The broadcast arrives in cycle T. `snoop_resp`/`snoop_dirty` are high in T+1 only (the bus completion cycle) and 0 otherwise.
- The array reflects the new state from T+2, including on `loc_rd_state`.
- With supply: `wb_valid` is high from T+2 and drops the cycle after the `wb_ready` handshake. `busy` is high T+1 through the handshake cycle.
- Without supply: `busy` is high in T+1 only, and the FSM accepts a new snoop at T+2. Bus spacing is ≥3 cycles, so the earliest next broadcast is T+3.
- A supply handshaken at T+2 still permits a snoop at T+3 without overrun.
- `loc_wr_ready` is low in T (capture cycle) and T+1 (UPDATE). This prevents lost updates to the snooped index.
- `loc_rd_state` is purely combinational from `loc_rd_addr` and the array; it has no latency.

## Test plan
- Reset, then query `loc_rd_addr` 0x0, 0x40 and 0x3C0 → `loc_rd_state`=0 for all. All outputs 0, `loc_wr_ready`=1.
- Local-install 0x1000 as M. Then BusRd 0x1000 from core 1 (CORE_ID=0) at T:
  - `snoop_resp`=`snoop_dirty`=1 in T+1.
  - `loc_rd_state`=3 (O) at T+2.
  - `wb_valid`=1, `wb_addr`=0x1000 from T+2, holding while `wb_ready`=0.
  - `wb_ready` pulsed at T+4 → `wb_valid`=0 at T+5.
- Install 0x2040 as S, then BusRdX 0x2040 from core 2 → `snoop_resp`=1 and `snoop_dirty`=0 at T+1. State I at T+2, no `wb_valid`.
- Install 0x1000 as S, then BusRd 0x1400 (same index, different tag) → `snoop_resp`=0; 0x1000 stays S. Repeat 0x1000 with `granted_core_id`=0 → no response, state unchanged.
- Install 0x80 as E, then BusUpgr 0x80 → `err_upgr`=1 and stays 1; state I.
- Install 0x80 as M, then issue a local write to 0xC0 in T and T+1 → `loc_wr_ready`=0 in those cycles, write lands at T+2.
- With a dirty supply pending and `wb_ready`=0, broadcast BusRd 0xC0 from core 3 → `err_overrun`=1, `snoop_resp`=0, 0xC0 state unchanged. Then `rst` → `wb_valid`=0 and `err_overrun`=0 next cycle.
